gray_step_decoder: RTL and testbench
====================================

Name: gray_step_decoder

Overview:
- Receive-side counterpart of the team's Gray-code sequence generator.
- Accepts a WIDTH-bit Gray-coded value that may come from another clock domain and synchronizes it.
- Decodes the value to binary and classifies every change as one step up, one step down, or an illegal jump.
- Keeps a signed up/down position count and an error/lock status; sits between a Gray source (counter, encoder, FIFO pointer) and local control logic.

Parameters:
WIDTH, 3, Gray/binary code width; legal range is 2 or more.
SYNC_STAGES, 2, synchronizer flop depth on gray_in; legal range is 2 or more.
CNT_W, 16, width of the position counter pos (two's complement).

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
gray_in  input  WIDTH  Gray-coded value, asynchronous to clk
en  input  1  enable tracking; 0 forces IDLE
clr_err  input  1  clears err_sticky (synchronous, one-cycle)
bin_out  output  WIDTH  registered binary decode of the synchronized Gray value
step_up  output  1  one-cycle pulse: value advanced by +1 (mod 2^WIDTH)
step_dn  output  1  one-cycle pulse: value moved by -1 (mod 2^WIDTH)
step_err  output  1  one-cycle pulse: illegal change (not 0, +1 or -1)
locked  output  1  high while FSM is in LOCKED
err_sticky  output  1  set by step_err, cleared by clr_err
pos  output  CNT_W  signed position: +1 per step_up, -1 per step_dn

Behaviour:
- Reset value of everything is 0: sync flops, bin_out, pos, all pulses, locked, err_sticky; FSM goes to IDLE.
- rst asserted mid-operation clears everything immediately, independent of clk.
- Synchronizer: SYNC_STAGES flops in series; the last stage is g_s.
- Decode is combinational: d[WIDTH-1] = g_s[WIDTH-1]; d[i] = d[i+1] XOR g_s[i].
- bin_out <= d on every clk edge, in every state.
- Latency: gray_in stable before edge 1 appears on bin_out and the pulses after edge SYNC_STAGES+1 (edge 3 by default).
- Classification compares d against the current bin_out, modulo 2^WIDTH:
  - d == bin_out: no event.
  - d == bin_out+1: up.
  - d == bin_out-1: dn.
  - anything else: err.
- FSM states:
  - IDLE: no pulses, pos held, locked=0. Goes to ACQUIRE when en=1.
  - ACQUIRE: one cycle; bin_out loads; no classification, no pulses. Goes to LOCKED, or to IDLE if en=0.
  - LOCKED: locked=1; pulses registered from the classification.
    - up: step_up=1, pos<=pos+1.
    - dn: step_dn=1, pos<=pos-1.
    - err: step_err=1, err_sticky<=1, pos unchanged, next state ACQUIRE.
    - en=0: next state IDLE, no pulse that cycle.
- At most one of step_up, step_dn, step_err is high in any cycle.
- pos wraps modulo 2^CNT_W with no saturation and no flag.
- bin_out wraps naturally: max to 0 counts as up, 0 to max counts as dn.
- locked drops for exactly one cycle after an error (ACQUIRE), then returns high.
- clr_err and a new step_err in the same cycle: set wins, err_sticky stays 1.
- clr_err alone: err_sticky is 0 after the next edge.
- err_sticky is unaffected by en.
- Parallel-bit skew on gray_in is out of scope; a legal Gray source changes one bit at a time.

Test Plan:
- Reset: rst=1 with gray_in=101 -> all outputs 0, FSM in IDLE. Release rst, en=1 -> locked=1 after 2 edges, bin_out=110 after SYNC_STAGES+1 edges, no pulse.
- Forward wrap: from 000, en=1, locked, step gray_in every 4 cycles through 001,011,010,110,111,101,100,000 -> 8 step_up pulses with bin_out 1..7 then 0, pos=8, no step_dn or step_err.
- Reverse: from locked at gray 000 with pos=0, apply 100,101,111 -> 3 step_dn pulses, bin_out 7,6,5, pos=0xFFFD (-3).
- Illegal jump: locked at 000, apply 011 (binary 2) -> one step_err pulse, err_sticky=1, pos unchanged, locked low exactly 1 cycle. Then 010 -> step_up, bin_out=3.
- clr_err precedence: clr_err=1 coincident with a second illegal jump -> err_sticky stays 1. clr_err alone next -> err_sticky=0.
- en and reset mid-run: en=0 while stepping -> no pulses, pos held, locked=0, bin_out keeps tracking. Then rst pulse mid-sequence -> pos=0, err_sticky=0, FSM in IDLE with no clk edge required.

Source files
------------

// File: rtl/gray_step_decoder.sv
// gray_step_decoder
// Receive side of a Gray-coded position source. It synchronizes gray_in,
// decodes it to binary and reports each change as a +1 step, a -1 step or an
// illegal jump. It also keeps a signed position count, a sticky error flag and
// a lock indication.
//
// Note: ACQUIRE lasts a single cycle and does not wait for the synchronizer to
// fill. If en rises within SYNC_STAGES cycles of a gray_in change, the first
// LOCKED cycle can therefore classify that change.
module gray_step_decoder #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_up,
  output logic             step_dn,
  output logic             step_err,
  output logic             locked,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pos
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = {WIDTH{1'b0}};
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] delta_s;
  logic             is_hold_s, is_up_s, is_dn_s;
  state_t           state_q, state_d;
  logic             step_up_q, step_up_d;
  logic             step_dn_q, step_dn_d;
  logic             step_err_q, step_err_d;
  logic             locked_q, locked_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] pos_q, pos_d;

  // Shift chain of the synchronizer; the last stage is the usable value.
  always_comb begin
    sync_d = sync_q;
    sync_d[0] = gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Decode and classify the new value against the value currently on bin_out.
  always_comb begin
    bin_d     = gray_to_bin(sync_q[SYNC_STAGES-1]);
    delta_s   = bin_d - bin_q;
    is_hold_s = (delta_s == {WIDTH{1'b0}});
    is_up_s   = (delta_s == {{(WIDTH-1){1'b0}}, 1'b1});
    is_dn_s   = (delta_s == {WIDTH{1'b1}});
  end

  // Next state, step pulses, position and error flag.
  always_comb begin
    state_d    = state_q;
    step_up_d  = 1'b0;
    step_dn_d  = 1'b0;
    step_err_d = 1'b0;
    pos_d      = pos_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = ACQUIRE;
        end else begin
          state_d = IDLE;
        end
      end
      ACQUIRE: begin
        if (en) begin
          state_d = LOCKED;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (!en) begin
          state_d = IDLE;
        end else if (is_hold_s) begin
          state_d = LOCKED;
        end else if (is_up_s) begin
          step_up_d = 1'b1;
          pos_d     = pos_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (is_dn_s) begin
          step_dn_d = 1'b1;
          pos_d     = pos_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          // An illegal jump forces a fresh acquire of the new value.
          step_err_d = 1'b1;
          state_d    = ACQUIRE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new error wins over a coincident clear.
    if (step_err_d) begin
      err_sticky_d = 1'b1;
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end

    locked_d = (state_d == LOCKED);
  end

  // All state registers; an asynchronous rst clears everything to zero and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      bin_q        <= {WIDTH{1'b0}};
      state_q      <= IDLE;
      step_up_q    <= 1'b0;
      step_dn_q    <= 1'b0;
      step_err_q   <= 1'b0;
      locked_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      pos_q        <= {CNT_W{1'b0}};
    end else begin
      sync_q       <= sync_d;
      bin_q        <= bin_d;
      state_q      <= state_d;
      step_up_q    <= step_up_d;
      step_dn_q    <= step_dn_d;
      step_err_q   <= step_err_d;
      locked_q     <= locked_d;
      err_sticky_q <= err_sticky_d;
      pos_q        <= pos_d;
    end
  end

  assign bin_out    = bin_q;
  assign step_up    = step_up_q;
  assign step_dn    = step_dn_q;
  assign step_err   = step_err_q;
  assign locked     = locked_q;
  assign err_sticky = err_sticky_q;
  assign pos        = pos_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Bench for gray_step_decoder: a cycle model built from the behavioural rules,
// a per-cycle comparison against it, and directed scenarios with literal values.
module tb_gray_step_decoder;

  localparam int W  = 3;
  localparam int SS = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  gray_in = 3'b101;
  logic          en = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  bin_out;
  logic          step_up, step_dn, step_err, locked, err_sticky;
  logic [CW-1:0] pos;

  int checks = 0;
  int errors = 0;
  int n_up = 0, n_dn = 0, n_err = 0;

  gray_step_decoder #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .en(en), .clr_err(clr_err),
    .bin_out(bin_out), .step_up(step_up), .step_dn(step_dn),
    .step_err(step_err), .locked(locked), .err_sticky(err_sticky), .pos(pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 acquiring, 2 tracking
  int            m_mode = 0;
  logic [W-1:0]  m_hist [SS];
  logic [W-1:0]  m_bin = '0;
  logic [CW-1:0] m_pos = '0;
  logic          m_up = 1'b0, m_dn = 1'b0, m_err = 1'b0, m_sticky = 1'b0;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int k = 1; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  initial for (int i = 0; i < SS; i++) m_hist[i] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SS; i++) m_hist[i] = '0;
      m_mode = 0; m_bin = '0; m_pos = '0;
      m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
    end else begin
      logic [W-1:0] nb;
      int diff;
      nb = g2b(m_hist[SS-1]);
      diff = (int'(nb) - int'(m_bin) + (1 << W)) % (1 << W);
      m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
      if (m_mode == 2 && en) begin
        if (diff == 1) begin m_up = 1'b1; m_pos = m_pos + 16'd1; end
        else if (diff == (1 << W) - 1) begin m_dn = 1'b1; m_pos = m_pos - 16'd1; end
        else if (diff != 0) m_err = 1'b1;
      end
      if (!en) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) m_mode = 2;
      else if (m_err) m_mode = 1;
      if (m_err) m_sticky = 1'b1;
      else if (clr_err) m_sticky = 1'b0;
      m_bin = nb;
      for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = gray_in;
    end
  end

  // Per-cycle comparison against the model, just after each active edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("bin_out", 32'(bin_out), 32'(m_bin));
      chk("step_up", 32'(step_up), 32'(m_up));
      chk("step_dn", 32'(step_dn), 32'(m_dn));
      chk("step_err", 32'(step_err), 32'(m_err));
      chk("locked", 32'(locked), 32'(m_mode == 2));
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
      chk("pos", 32'(pos), 32'(m_pos));
      chk("one_hot_pulse", 32'(step_up + step_dn + step_err <= 2'd1), 32'd1);
      if (step_up) n_up++;
      if (step_dn) n_dn++;
      if (step_err) n_err++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart(input logic [W-1:0] g);
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; gray_in = g;
    cyc(1);
    rst = 1'b0;
    cyc(SS + 2);
    en = 1'b1;
    cyc(3);
    chk("restart_locked", 32'(locked), 32'd1);
  endtask

  logic [W-1:0] fwd_g [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [W-1:0] fwd_b [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [W-1:0] rev_g [3] = '{3'b100, 3'b101, 3'b111};
  logic [W-1:0] rev_b [3] = '{3'd7, 3'd6, 3'd5};

  initial begin
    int b_up, b_dn, b_err;

    // Reset with gray_in = 101 held.
    cyc(2);
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_pulses", 32'({step_up, step_dn, step_err}), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);
    rst = 1'b0;
    cyc(SS + 1);
    chk("init_bin_110", 32'(bin_out), 32'd6);
    en = 1'b1;
    cyc(1);
    chk("init_not_locked_1edge", 32'(locked), 32'd0);
    cyc(1);
    chk("init_locked_2edges", 32'(locked), 32'd1);
    cyc(3);
    chk("init_no_err", 32'(n_err), 32'd0);
    chk("init_no_up", 32'(n_up), 32'd0);

    // Forward walk with wrap.
    restart(3'b000);
    b_up = n_up; b_dn = n_dn; b_err = n_err;
    for (int i = 0; i < 8; i++) begin
      gray_in = fwd_g[i];
      cyc(4);
      chk("fwd_bin", 32'(bin_out), 32'(fwd_b[i]));
    end
    chk("fwd_up_count", 32'(n_up - b_up), 32'd8);
    chk("fwd_dn_count", 32'(n_dn - b_dn), 32'd0);
    chk("fwd_err_count", 32'(n_err - b_err), 32'd0);
    chk("fwd_pos", 32'(pos), 32'd8);

    // Reverse walk below zero.
    restart(3'b000);
    b_up = n_up; b_dn = n_dn;
    for (int i = 0; i < 3; i++) begin
      gray_in = rev_g[i];
      cyc(4);
      chk("rev_bin", 32'(bin_out), 32'(rev_b[i]));
    end
    chk("rev_dn_count", 32'(n_dn - b_dn), 32'd3);
    chk("rev_up_count", 32'(n_up - b_up), 32'd0);
    chk("rev_pos", 32'(pos), 32'h0000_FFFD);

    // Illegal jump 0 -> 2, then a legal step to 3.
    restart(3'b000);
    gray_in = 3'b011;
    cyc(2);
    chk("ill_pre_err", 32'(step_err), 32'd0);
    chk("ill_pre_locked", 32'(locked), 32'd1);
    cyc(1);
    chk("ill_err", 32'(step_err), 32'd1);
    chk("ill_unlocked", 32'(locked), 32'd0);
    chk("ill_sticky", 32'(err_sticky), 32'd1);
    chk("ill_bin", 32'(bin_out), 32'd2);
    cyc(1);
    chk("ill_relocked", 32'(locked), 32'd1);
    chk("ill_err_gone", 32'(step_err), 32'd0);
    chk("ill_pos", 32'(pos), 32'd0);
    b_up = n_up;
    gray_in = 3'b010;
    cyc(4);
    chk("ill_after_bin", 32'(bin_out), 32'd3);
    chk("ill_after_up", 32'(n_up - b_up), 32'd1);

    // clr_err coincident with a second illegal jump (3 -> 0), then alone.
    gray_in = 3'b000;
    cyc(2);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    chk("clr_coinc_err", 32'(step_err), 32'd1);
    chk("clr_coinc_sticky", 32'(err_sticky), 32'd1);
    cyc(2);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    chk("clr_alone_sticky", 32'(err_sticky), 32'd0);

    // en low while stepping: tracking continues, no pulses, pos held.
    b_up = n_up; b_dn = n_dn; b_err = n_err;
    en = 1'b0;
    gray_in = 3'b001;
    cyc(4);
    chk("en0_bin1", 32'(bin_out), 32'd1);
    chk("en0_locked", 32'(locked), 32'd0);
    gray_in = 3'b011;
    cyc(4);
    chk("en0_bin2", 32'(bin_out), 32'd2);
    chk("en0_pos", 32'(pos), 32'd1);
    chk("en0_no_pulses", 32'((n_up - b_up) + (n_dn - b_dn) + (n_err - b_err)), 32'd0);
    en = 1'b1;
    cyc(3);
    chk("en1_relock", 32'(locked), 32'd1);
    gray_in = 3'b000;
    cyc(4);
    chk("pre_rst_sticky", 32'(err_sticky), 32'd1);

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b1;
    #1;
    chk("arst_pos", 32'(pos), 32'd0);
    chk("arst_sticky", 32'(err_sticky), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_bin", 32'(bin_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
